nibble_demux: RTL

- Receives a time-multiplexed WIDTH-bit stream tagged with a one-bit select and steers each beat into one of two output channels, X (select 0) or Y (select 1).
- Each channel has its own 2-entry FIFO and a valid/ready handshake.
- It is the receiving end of the two-to-one nibble multiplexer path: it recovers the separate X and Y streams that the multiplexer merged onto one bus.
- It sits between the shared bus and the per-channel consumers (LED drivers, seven-segment decoders).

---
 rtl/nibble_demux_pkg.sv | 12 +
 rtl/demux_chan_fifo.sv | 76 +++++++
 rtl/nibble_demux.sv | 58 +++++
 3 files changed

// File: rtl/nibble_demux_pkg.sv
// nibble_demux shared constants and types.
// Build option: NIBBLE_DEMUX_STATS_EN enables per-channel accepted-beat counters.
package nibble_demux_pkg;
  localparam logic CH_X  = 1'b0;
  localparam logic CH_Y  = 1'b1;
  localparam int   DEPTH = 2;
  localparam int   CNT_W = 8;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_FULL = occ_t'(DEPTH);
endpackage

// File: rtl/demux_chan_fifo.sv
// Two-entry channel FIFO with registered head and optional push counter.
// Build option: NIBBLE_DEMUX_STATS_EN builds the saturating counter.
module demux_chan_fifo
  import nibble_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  occ_t             occ_q, occ_d;
  logic             push, pop;

  assign full_o  = (occ_q == OCC_FULL);
  assign valid_o = (occ_q != '0);
  assign data_o  = mem_q[rd_ptr_q];

  assign push = push_i & ~full_o;
  assign pop  = valid_o & ready_i;

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= data_i;
    end
  end

`ifdef NIBBLE_DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate rather than wrap so a stuck stream stays visible.
  always_comb begin
    cnt_d = cnt_q;
    if (push && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
`else
  assign count_o = '0;
`endif

endmodule

// File: rtl/nibble_demux.sv
// Steers a select-tagged beat stream into X and Y channel FIFOs.
// Build option: NIBBLE_DEMUX_STATS_EN enables x_count/y_count.
module nibble_demux
  import nibble_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] x_data,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [CNT_W-1:0] x_count,
  output logic [CNT_W-1:0] y_count
);

  logic x_full, y_full;
  logic x_push, y_push;
  logic accept;

  // Only combinational path: in_sel picks which full flag gates in_ready.
  assign in_ready = (in_sel == CH_Y) ? ~y_full : ~x_full;
  assign accept   = in_valid & in_ready;
  assign x_push   = accept & (in_sel == CH_X);
  assign y_push   = accept & (in_sel == CH_Y);

  demux_chan_fifo #(.WIDTH(WIDTH)) u_x_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .push_i  (x_push),
    .data_i  (in_data),
    .full_o  (x_full),
    .valid_o (x_valid),
    .ready_i (x_ready),
    .data_o  (x_data),
    .count_o (x_count)
  );

  demux_chan_fifo #(.WIDTH(WIDTH)) u_y_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .push_i  (y_push),
    .data_i  (in_data),
    .full_o  (y_full),
    .valid_o (y_valid),
    .ready_i (y_ready),
    .data_o  (y_data),
    .count_o (y_count)
  );

endmodule
